vga_frame_driver: RTL and testbench



---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_axis_counter.sv | 41 ++++
 rtl/vga_frame_driver.sv | 126 ++++++++++++
 tb/tb_vga_frame_driver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: default 640x480@60 timing and the 10-bit coordinate type
// that the level renderers consume as col/row.
package vga_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL      = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL      = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START = H_VISIBLE_DEF + H_FP_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int V_SYNC_START = V_VISIBLE_DEF + V_FP_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

    localparam int BAR_WIDTH = 80;

    // Colour-bar index for the built-in test pattern: eight bars of BAR_WIDTH pixels.
    function automatic logic [2:0] bar_index(input coord_t x);
        return 3'(x / coord_t'(BAR_WIDTH));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync and visible-region flags.
// Latency: count updates on the clk after en; flags are combinational from count.
// Backpressure: none, free-running whenever en is high.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = H_VISIBLE_DEF,
    parameter int FP      = H_FP_DEF,
    parameter int SYNC    = H_SYNC_DEF,
    parameter int BP      = H_BP_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    output coord_t count,
    output logic   wrap,
    output logic   sync,
    output logic   visible
);

    localparam int TOTAL      = VISIBLE + FP + SYNC + BP;
    localparam int SYNC_START = VISIBLE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC - 1;

    if (TOTAL > 1023) begin : g_total_too_big
        $error("vga_axis_counter: total of %0d does not fit the 10-bit counter", TOTAL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + coord_t'(1);
        end
    end

    assign wrap    = en && (count == coord_t'(TOTAL - 1));
    assign sync    = (count >= coord_t'(SYNC_START)) && (count <= coord_t'(SYNC_END));
    assign visible = count < coord_t'(VISIBLE);

endmodule

// File: rtl/vga_frame_driver.sv
// VGA pixel-timing master: raster counters, blank-masked registered colour and syncs, frame tick.
// Latency: col/row to DAC pins is one pixel (2 clk); VGA_TEST_PATTERN_EN swaps rgb_* for colour bars.
// Backpressure: none, the raster never stalls.
module vga_frame_driver
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rgb_r,
    input  logic [7:0] rgb_g,
    input  logic [7:0] rgb_b,
    output coord_t     col,
    output coord_t     row,
    output logic       pix_en,
    output logic       frame_tick,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);

    logic       h_wrap;
    logic       h_sync;
    logic       h_vis;
    logic       v_wrap_unused;
    logic       v_sync;
    logic       v_vis;
    logic       visible;
    logic [7:0] src_r;
    logic [7:0] src_g;
    logic [7:0] src_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .en      (pix_en),
        .count   (col),
        .wrap    (h_wrap),
        .sync    (h_sync),
        .visible (h_vis)
    );

    // Vertical axis advances only when the horizontal axis wraps.
    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .en      (h_wrap),
        .count   (row),
        .wrap    (v_wrap_unused),
        .sync    (v_sync),
        .visible (v_vis)
    );

    assign visible = h_vis && v_vis;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]  bar;
    logic [23:0] rgb_unused;

    assign bar        = bar_index(col);
    assign src_r      = {8{bar[2]}};
    assign src_g      = {8{bar[1]}};
    assign src_b      = {8{bar[0]}};
    assign rgb_unused = {rgb_r, rgb_g, rgb_b};
`else
    assign src_r = rgb_r;
    assign src_g = rgb_g;
    assign src_b = rgb_b;
`endif

    // Colour, syncs and blank share one pixel stage so they reach the DAC aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else if (pix_en) begin
            VGA_R       <= visible ? src_r : '0;
            VGA_G       <= visible ? src_g : '0;
            VGA_B       <= visible ? src_b : '0;
            VGA_HS      <= ~h_sync;
            VGA_VS      <= ~v_sync;
            VGA_BLANK_N <= visible;
        end
    end

    // Fires at the start of vertical blanking so game state updates land off-screen.
    assign frame_tick = pix_en && (col == '0) && (row == coord_t'(V_VISIBLE));
    assign VGA_SYNC_N = 1'b0;
    assign VGA_CLK    = pix_en;

endmodule

// File: tb/tb_vga_frame_driver.sv
// Bench for vga_frame_driver: a full-size instance and a shrunken-timing instance checked
// every clk against an arithmetic raster model driven by randomised renderer colour.
module tb_vga_frame_driver;

    typedef struct {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
    } tim_t;

    typedef struct {
        int col; int row; int pix; int tick;
        int hs; int vs; int vis; int qc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rgb_r, rgb_g, rgb_b;

    logic [9:0] d_col, d_row, s_col, s_row;
    logic       d_pix, d_tick, d_hs, d_vs, d_bn, d_sn, d_vc;
    logic       s_pix, s_tick, s_hs, s_vs, s_bn, s_sn, s_vc;
    logic [7:0] d_r, d_g, d_b, s_r, s_g, s_b;

    logic [7:0] d_er, d_eg, d_eb, s_er, s_eg, s_eb;
    int checks = 0;
    int passed = 0;
    tim_t td, ts;

    always #10 clk = ~clk;

    vga_frame_driver dut_d (
        .clk(clk), .reset(reset), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .col(d_col), .row(d_row), .pix_en(d_pix), .frame_tick(d_tick),
        .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b), .VGA_HS(d_hs), .VGA_VS(d_vs),
        .VGA_BLANK_N(d_bn), .VGA_SYNC_N(d_sn), .VGA_CLK(d_vc)
    );

    vga_frame_driver #(
        .H_VISIBLE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VISIBLE(30), .V_FP(3), .V_SYNC(2), .V_BP(5)
    ) dut_s (
        .clk(clk), .reset(reset), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .col(s_col), .row(s_row), .pix_en(s_pix), .frame_tick(s_tick),
        .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
        .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn), .VGA_CLK(s_vc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Raster state after n clk edges since reset release, from pixel arithmetic alone.
    function automatic exp_t model(input tim_t t, input int n);
        exp_t e;
        int ht, vt, p, q, qr, sh0, sv0;
        ht = t.hv + t.hf + t.hs + t.hb;
        vt = t.vv + t.vf + t.vs + t.vb;
        p = n / 2;
        e.pix  = n % 2;
        e.col  = p % ht;
        e.row  = (p / ht) % vt;
        e.tick = (e.pix == 1 && e.col == 0 && e.row == t.vv) ? 1 : 0;
        e.qc   = 0;
        if (n < 2) begin
            e.hs = 1; e.vs = 1; e.vis = 0;
        end else begin
            q    = p - 1;
            e.qc = q % ht;
            qr   = (q / ht) % vt;
            sh0  = t.hv + t.hf;
            sv0  = t.vv + t.vf;
            e.vis = (e.qc < t.hv && qr < t.vv) ? 1 : 0;
            e.hs  = (e.qc >= sh0 && e.qc < sh0 + t.hs) ? 0 : 1;
            e.vs  = (qr >= sv0 && qr < sv0 + t.vs) ? 0 : 1;
        end
        return e;
    endfunction

    task automatic check_inst(
        input string nm, input tim_t t, input int n,
        input logic [9:0] col, input logic [9:0] row, input logic pix, input logic tick,
        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
        input logic hs, input logic vs, input logic bn, input logic sn, input logic vc,
        inout logic [7:0] er, inout logic [7:0] eg, inout logic [7:0] eb);
        exp_t e;
        int idx;
        e = model(t, n);
        if (n == 0) begin
            er = 8'h00; eg = 8'h00; eb = 8'h00;
        end else if (n >= 2 && n % 2 == 0) begin
`ifdef VGA_TEST_PATTERN_EN
            idx = e.qc / 80;
            er = (e.vis == 1 && (idx & 4) != 0) ? 8'hff : 8'h00;
            eg = (e.vis == 1 && (idx & 2) != 0) ? 8'hff : 8'h00;
            eb = (e.vis == 1 && (idx & 1) != 0) ? 8'hff : 8'h00;
`else
            idx = 0;
            er = (e.vis == 1) ? rgb_r : 8'h00;
            eg = (e.vis == 1) ? rgb_g : 8'h00;
            eb = (e.vis == 1) ? rgb_b : 8'h00;
`endif
        end
        chk({nm, "_col"},   32'(col),  32'(e.col));
        chk({nm, "_row"},   32'(row),  32'(e.row));
        chk({nm, "_pix"},   32'(pix),  32'(e.pix));
        chk({nm, "_tick"},  32'(tick), 32'(e.tick));
        chk({nm, "_r"},     32'(r),    32'(er));
        chk({nm, "_g"},     32'(g),    32'(eg));
        chk({nm, "_b"},     32'(b),    32'(eb));
        chk({nm, "_hs"},    32'(hs),   32'(e.hs));
        chk({nm, "_vs"},    32'(vs),   32'(e.vs));
        chk({nm, "_blank"}, 32'(bn),   32'(e.vis));
        chk({nm, "_syncn"}, 32'(sn),   32'(0));
        chk({nm, "_vgaclk"}, 32'(vc),  32'(e.pix));
    endtask

    task automatic check_all(input int n);
        check_inst("d", td, n, d_col, d_row, d_pix, d_tick, d_r, d_g, d_b,
                   d_hs, d_vs, d_bn, d_sn, d_vc, d_er, d_eg, d_eb);
        check_inst("s", ts, n, s_col, s_row, s_pix, s_tick, s_r, s_g, s_b,
                   s_hs, s_vs, s_bn, s_sn, s_vc, s_er, s_eg, s_eb);
    endtask

    initial begin
        int n, s_ticks, s_t0, s_t1, d_ticks, hs_low;
        td = '{640, 16, 96, 48, 480, 10, 2, 33};
        ts = '{40, 4, 8, 4, 30, 3, 2, 5};
        reset = 1'b1;
        rgb_r = 8'hc8; rgb_g = 8'h00; rgb_b = 8'h00;
        d_er = '0; d_eg = '0; d_eb = '0; s_er = '0; s_eg = '0; s_eb = '0;
        s_ticks = 0; s_t0 = 0; s_t1 = 0; d_ticks = 0; hs_low = 0;

        // Reset held for 5 clk: outputs sit at reset values.
        repeat (5) begin
            @(posedge clk); #1;
            check_all(0);
        end
        reset = 1'b0;

        // Two-plus small frames; the first line of the full-size raster uses constant red c8.
        n = 0;
        for (int i = 0; i < 9960; i++) begin
            @(posedge clk); #1;
            n++;
            check_all(n);
            if (s_tick === 1'b1) begin
                s_ticks++;
                if (s_ticks == 1) s_t0 = n; else s_t1 = n;
                chk("s_tick_row", 32'(s_row), 32'(30));
                chk("s_tick_col", 32'(s_col), 32'(0));
            end
            if (d_tick === 1'b1) d_ticks++;
            if (n >= 2 && n <= 1601 && d_hs === 1'b0) hs_low++;
            rgb_r = (n < 1700) ? 8'hc8 : 8'($urandom);
            rgb_g = 8'($urandom);
            rgb_b = 8'($urandom);
        end
        chk("s_tick_count", 32'(s_ticks), 32'(2));
        chk("s_tick_spacing", 32'(s_t1 - s_t0), 32'(4480));
        chk("s_tick_first", 32'(s_t0), 32'(3361));
        chk("d_tick_none", 32'(d_ticks), 32'(0));
        chk("d_hs_low_clks", 32'(hs_low), 32'(192));

        // Reset mid-frame: one clk of reset returns everything to reset values.
        reset = 1'b1;
        @(posedge clk); #1;
        check_all(0);
        reset = 1'b0;

        n = 0;
        s_ticks = 0; s_t0 = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            n++;
            check_all(n);
            if (s_tick === 1'b1) begin
                s_ticks++;
                if (s_ticks == 1) s_t0 = n;
            end
            rgb_r = 8'($urandom);
            rgb_g = 8'($urandom);
            rgb_b = 8'($urandom);
        end
        chk("s_tick_after_reset_count", 32'(s_ticks), 32'(1));
        chk("s_tick_after_reset_at", 32'(s_t0), 32'(3361));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
